// File: rtl/vga_fb_scheduler.sv
// 640x480@60 VGA scanout of a 160x120x3 framebuffer (4x4 pixel scaling) with a shared host RAM port.
// Optional feature: define VGA_FB_BORDER_EN to force rgb=3'b111 on the outermost visible pixels.
module vga_fb_scheduler (
    input  logic        clk25MHz,
    input  logic        rst,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  rgb,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [2:0]  ram_wdata,
    input  logic [2:0]  ram_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [2:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [2:0]  cpu_rdata
);
    localparam logic [9:0]  H_VISIBLE    = 10'd640;
    localparam logic [9:0]  H_SYNC_START = 10'd656;
    localparam logic [9:0]  H_SYNC_END   = 10'd752;
    localparam logic [9:0]  H_LAST       = 10'd799;
    localparam logic [9:0]  H_LAST_SLOT  = 10'd636;
    localparam logic [9:0]  H_WRAP_SLOT  = 10'd796;
    localparam logic [9:0]  V_VISIBLE    = 10'd480;
    localparam logic [9:0]  V_SYNC_START = 10'd490;
    localparam logic [9:0]  V_SYNC_END   = 10'd492;
    localparam logic [9:0]  V_LAST       = 10'd524;
    localparam logic [14:0] FB_WORDS     = 15'd19200;
    localparam logic [14:0] ROW_WORDS    = 15'd160;

    typedef enum logic {IDLE, ACK} host_state_t;

    host_state_t state;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [14:0] line_base;
    logic [14:0] next_base;
    logic [14:0] disp_addr;
    logic [14:0] addr_hold;
    logic [2:0]  fetch_buf;
    logic [2:0]  pix;
    logic [2:0]  pix_colour;
    logic        ready;
    logic        ack_zero;
    logic        h_end;
    logic        v_end;
    logic        visible;
    logic        slot_mid;
    logic        slot_wrap;
    logic        disp_slot;
    logic        host_grant;
    logic        cpu_in_range;

    assign h_end   = (hcount == H_LAST);
    assign v_end   = (vcount == V_LAST);
    assign visible = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);

    // Base of the line that follows the current one; the incremental update avoids a multiplier.
    assign next_base = v_end                  ? 15'd0 :
                       (vcount[1:0] == 2'd3)  ? line_base + ROW_WORDS :
                                                line_base;

    assign slot_mid  = (hcount[1:0] == 2'd0) && (hcount <= H_LAST_SLOT) && (vcount < V_VISIBLE);
    assign slot_wrap = (hcount == H_WRAP_SLOT) && (v_end || (vcount < V_VISIBLE - 10'd1));
    assign disp_slot = ready && (slot_mid || slot_wrap);
    assign disp_addr = slot_wrap ? next_base : line_base + {7'd0, hcount[9:2]} + 15'd1;

    // ready blocks all RAM traffic in the first cycle after reset so every output shows its reset value.
    assign cpu_in_range = (cpu_addr < FB_WORDS);
    assign host_grant   = ready && !rst && (state == IDLE) && cpu_req && !disp_slot;

    always_comb begin
        ram_addr  = addr_hold;
        ram_we    = 1'b0;
        ram_wdata = 3'b000;
        if (disp_slot) begin
            ram_addr = disp_addr;
        end else if (host_grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we && cpu_in_range;
            ram_wdata = cpu_wdata;
        end
    end

    assign cpu_rdata = ((state == ACK) && !ack_zero) ? ram_rdata : 3'b000;

`ifdef VGA_FB_BORDER_EN
    logic on_border;
    assign on_border  = (hcount == 10'd0) || (hcount == H_VISIBLE - 10'd1) ||
                        (vcount == 10'd0) || (vcount == V_VISIBLE - 10'd1);
    assign pix_colour = on_border ? 3'b111 : pix;
`else
    assign pix_colour = pix;
`endif

    // Fetched word lands one cycle after its slot and is promoted to pix just before its group starts.
    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            hcount    <= 10'd0;
            vcount    <= 10'd0;
            line_base <= 15'd0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            rgb       <= 3'b000;
            fetch_buf <= 3'b000;
            pix       <= 3'b000;
            addr_hold <= 15'd0;
            ready     <= 1'b0;
        end else begin
            ready     <= 1'b1;
            addr_hold <= ram_addr;
            hcount    <= h_end ? 10'd0 : hcount + 10'd1;
            if (h_end) begin
                vcount    <= v_end ? 10'd0 : vcount + 10'd1;
                line_base <= next_base;
            end
            hsync <= !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
            vsync <= !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
            rgb   <= visible ? pix_colour : 3'b000;
            if (hcount[1:0] == 2'd1) fetch_buf <= ram_rdata;
            if (hcount[1:0] == 2'd3) pix <= fetch_buf;
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            state    <= IDLE;
            cpu_ack  <= 1'b0;
            ack_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_grant) begin
                        state    <= ACK;
                        cpu_ack  <= 1'b1;
                        ack_zero <= cpu_we || !cpu_in_range;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    cpu_ack <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    cpu_ack <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler: sync timing, pixel path, host port arbitration and reset behaviour.
module tb_vga_fb_scheduler;
    logic        clk25MHz = 1'b0;
    logic        rst;
    logic        hsync;
    logic        vsync;
    logic [2:0]  rgb;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [2:0]  ram_wdata;
    logic [2:0]  ram_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [2:0]  cpu_wdata;
    logic        cpu_ack;
    logic [2:0]  cpu_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t = 0;
    int sync_bad = 0;
    int rgb_bad = 0;
    int hs_low_cnt = 0;
    int first_low_ph = -1;
    logic preload;
    logic [2:0] mem     [0:32767];
    logic [2:0] exp_mem [0:32767];
    logic [2:0] scr     [0:15][0:15];

    always #5 clk25MHz = ~clk25MHz;

    vga_fb_scheduler dut (
        .clk25MHz (clk25MHz),
        .rst      (rst),
        .hsync    (hsync),
        .vsync    (vsync),
        .rgb      (rgb),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata)
    );

    function automatic logic [2:0] pat(input int i);
        return 3'((i * 3 + i / 160 + 2) % 8);
    endfunction

    // Single-port synchronous RAM: read data one cycle after the address, old data on read-during-write.
    always @(posedge clk25MHz) begin
        if (preload) begin
            for (int i = 0; i < 32768; i++) mem[i] <= pat(i);
        end else begin
            if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge clk25MHz) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [2:0] exp_pixel(input int ph, input int pv);
        logic [2:0] c;
        c = exp_mem[15'((pv / 4) * 160 + ph / 4)];
`ifdef VGA_FB_BORDER_EN
        if (ph == 0 || ph == 639 || pv == 0 || pv == 479) c = 3'b111;
`endif
        return c;
    endfunction

    // Advance one cycle and compare the video outputs against the counter model for the previous cycle.
    task automatic step();
        int ph;
        int pv;
        logic exp_hs;
        logic exp_vs;
        logic vis;
        logic [2:0] exp_rgb;
        @(posedge clk25MHz);
        #1;
        t = cyc;
        if (t >= 1) begin
            ph = (t - 1) % 800;
            pv = ((t - 1) / 800) % 525;
            exp_hs = !(ph >= 656 && ph < 752);
            exp_vs = !(pv >= 490 && pv < 492);
            vis = (ph < 640) && (pv < 480);
            exp_rgb = vis ? exp_pixel(ph, pv) : 3'b000;
            if (hsync !== exp_hs || vsync !== exp_vs) sync_bad++;
            if (hsync === 1'b0) begin
                hs_low_cnt++;
                if (first_low_ph < 0) first_low_ph = ph;
            end
            if (pv != 0 && rgb !== exp_rgb) rgb_bad++;
            if (vis && pv < 16 && ph < 16) scr[pv][ph] = rgb;
        end
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic test_reset();
        preload = 1'b1;
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 15'd0;
        cpu_wdata = 3'd0;
        @(posedge clk25MHz);
        #1;
        preload = 1'b0;
        step();
        checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_vsync: got %b want 1", vsync); end
        checks++; if (rgb !== 3'd0) begin errors++; $display("[TB] FAIL reset_rgb: got %0d want 0", rgb); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b want 0", cpu_ack); end
        checks++; if (cpu_rdata !== 3'd0) begin errors++; $display("[TB] FAIL reset_rdata: got %0d want 0", cpu_rdata); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", ram_we); end
        checks++; if (ram_addr !== 15'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", ram_addr); end
        checks++; if (ram_wdata !== 3'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %0d want 0", ram_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_sync();
        hs_low_cnt = 0;
        first_low_ph = -1;
        run_to(2400);
        checks++; if (sync_bad !== 0) begin errors++; $display("[TB] FAIL sync_cycles: got %0d bad cycles want 0", sync_bad); end
        checks++; if (hs_low_cnt !== 288) begin errors++; $display("[TB] FAIL hsync_width: got %0d low cycles want 288", hs_low_cnt); end
        checks++; if (first_low_ph !== 656) begin errors++; $display("[TB] FAIL hsync_start: got %0d want 656", first_low_ph); end
    endtask

    task automatic test_host_write();
        run_to(3100);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd161; cpu_wdata = 3'd5;
        exp_mem[161] = 3'd5;
        #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_grant_we: got %b want 1", ram_we); end
        checks++; if (ram_addr !== 15'd161) begin errors++; $display("[TB] FAIL wr_grant_addr: got %0d want 161", ram_addr); end
        checks++; if (ram_wdata !== 3'd5) begin errors++; $display("[TB] FAIL wr_grant_data: got %0d want 5", ram_wdata); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_early_ack: got %b want 0", cpu_ack); end
        step();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL wr_ack: got %b want 1", cpu_ack); end
        cpu_req = 1'b0;
        step();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL wr_ack_width: got %b want 0", cpu_ack); end
        checks++; if (mem[161] !== 3'd5) begin errors++; $display("[TB] FAIL wr_ram: got %0d want 5", mem[161]); end
    endtask

    task automatic test_pixels();
        run_to(8 * 800 + 20);
        checks++; if (scr[4][4] !== 3'd5) begin errors++; $display("[TB] FAIL px_4_4: got %0d want 5", scr[4][4]); end
        checks++; if (scr[7][7] !== 3'd5) begin errors++; $display("[TB] FAIL px_7_7: got %0d want 5", scr[7][7]); end
        checks++; if (scr[5][3] !== 3'd3) begin errors++; $display("[TB] FAIL px_3_5: got %0d want 3", scr[5][3]); end
        checks++; if (scr[6][8] !== 3'd1) begin errors++; $display("[TB] FAIL px_8_6: got %0d want 1", scr[6][8]); end
        checks++; if (scr[8][4] !== 3'd7) begin errors++; $display("[TB] FAIL px_4_8: got %0d want 7", scr[8][4]); end
        checks++; if (rgb_bad !== 0) begin errors++; $display("[TB] FAIL rgb_cycles: got %0d bad cycles want 0", rgb_bad); end
    endtask

    task automatic test_slot_conflict();
        run_to(9 * 800 + 8);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5000; cpu_wdata = 3'd7;
        exp_mem[5000] = 3'd7;
        #1;
        checks++; if (ram_addr !== 15'd323) begin errors++; $display("[TB] FAIL slot_addr: got %0d want 323", ram_addr); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL slot_we: got %b want 0", ram_we); end
        step();
        checks++; if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL slot_grant_we: got %b want 1", ram_we); end
        checks++; if (ram_addr !== 15'd5000) begin errors++; $display("[TB] FAIL slot_grant_addr: got %0d want 5000", ram_addr); end
        step();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL slot_ack: got %b want 1", cpu_ack); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL slot_ack_we: got %b want 0", ram_we); end
        cpu_req = 1'b0;
        step();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL slot_ack_width: got %b want 0", cpu_ack); end
    endtask

    task automatic test_read_boundary();
        run_to(9 * 800 + 650);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd19199; cpu_wdata = 3'd3;
        exp_mem[19199] = 3'd3;
        #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL edge_wr_we: got %b want 1", ram_we); end
        step();
        cpu_req = 1'b0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd19199;
        #1;
        checks++; if (ram_addr !== 15'd19199) begin errors++; $display("[TB] FAIL rd_addr: got %0d want 19199", ram_addr); end
        step();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL rd_ack: got %b want 1", cpu_ack); end
        checks++; if (cpu_rdata !== 3'd3) begin errors++; $display("[TB] FAIL rd_data: got %0d want 3", cpu_rdata); end
        cpu_req = 1'b0;
        step();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_ack_width: got %b want 0", cpu_ack); end
        checks++; if (cpu_rdata !== 3'd0) begin errors++; $display("[TB] FAIL rd_data_after: got %0d want 0", cpu_rdata); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd19200;
        step();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL oor_rd_ack: got %b want 1", cpu_ack); end
        checks++; if (cpu_rdata !== 3'd0) begin errors++; $display("[TB] FAIL oor_rd_data: got %0d want 0", cpu_rdata); end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_oor_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd19200; cpu_wdata = 3'd5;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL oor_wr_we: got %b want 0", ram_we); end
        step();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL oor_wr_ack: got %b want 1", cpu_ack); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL oor_wr_we_ack: got %b want 0", ram_we); end
        cpu_req = 1'b0;
        step();
        checks++; if (mem[19200] !== 3'd2) begin errors++; $display("[TB] FAIL oor_wr_ram: got %0d want 2", mem[19200]); end
    endtask

    task automatic test_reset_mid_access();
        run_to(9 * 800 + 700);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd400; cpu_wdata = 3'd0;
        rst = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_cycle_we: got %b want 0", ram_we); end
        step();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack: got %b want 0", cpu_ack); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL rst_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("[TB] FAIL rst_vsync: got %b want 1", vsync); end
        checks++; if (rgb !== 3'd0) begin errors++; $display("[TB] FAIL rst_rgb: got %0d want 0", rgb); end
        checks++; if (cpu_rdata !== 3'd0) begin errors++; $display("[TB] FAIL rst_rdata: got %0d want 0", cpu_rdata); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_we: got %b want 0", ram_we); end
        checks++; if (ram_addr !== 15'd0) begin errors++; $display("[TB] FAIL rst_addr: got %0d want 0", ram_addr); end
        checks++; if (ram_wdata !== 3'd0) begin errors++; $display("[TB] FAIL rst_wdata: got %0d want 0", ram_wdata); end
        rst = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_we: got %b want 0", ram_we); end
        cpu_req = 1'b0;
        step();
        checks++; if (mem[400] !== 3'd4) begin errors++; $display("[TB] FAIL rst_ram: got %0d want 4", mem[400]); end
    endtask

    task automatic test_after_reset();
        run_to(2 * 800 + 10);
        checks++; if (sync_bad !== 0) begin errors++; $display("[TB] FAIL final_sync: got %0d bad cycles want 0", sync_bad); end
        checks++; if (rgb_bad !== 0) begin errors++; $display("[TB] FAIL final_rgb: got %0d bad cycles want 0", rgb_bad); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) exp_mem[i] = pat(i);
        test_reset();
        test_sync();
        test_host_write();
        test_pixels();
        test_slot_conflict();
        test_read_boundary();
        test_oor_write();
        test_reset_mid_access();
        test_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at t=%0d", t);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
